// File: rtl/force_mon_pkg.sv
// Shared types and helpers for the force/release change monitor.
package force_mon_pkg;

  typedef enum logic [1:0] {
    S_PRIME  = 2'd0,
    S_TRACK  = 2'd1,
    S_FORCED = 2'd2,
    S_SETTLE = 2'd3
  } state_t;

  localparam int DEFAULT_CNT_W = 16;

  // Increment v, holding at 2^w-1 (w up to 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/force_mon_sat_cnt.sv
// Saturating counter with clear, load-to-one and increment controls (clear has priority).
module force_mon_sat_cnt
  import force_mon_pkg::*;
#(
  parameter int W = DEFAULT_CNT_W
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (load1)
      cnt <= W'(1);
    else if (inc)
      cnt <= W'(sat_inc(32'(cnt), W));
  end

endmodule

// File: rtl/force_change_monitor.sv
// Observes a forceable register and reports force episodes (count, duration, forced value).
// Optional build macro FORCE_CHANGE_MONITOR_TRACE_EN prints start/end events.
module force_change_monitor
  import force_mon_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int CNT_W  = DEFAULT_CNT_W,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] expected_i,
  input  logic [WIDTH-1:0] observed_i,
  output logic             forced_o,
  output logic             force_start_o,
  output logic             force_end_o,
  output logic [WIDTH-1:0] forced_value_o,
  output logic [CNT_W-1:0] episode_cnt_o,
  output logic [CNT_W-1:0] last_duration_o
);

  localparam int SET_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  state_t           state;
  logic [WIDTH-1:0] exp_q;
  logic             match;
  logic [CNT_W-1:0] dur_cnt;
  logic [SET_W-1:0] set_cnt;
  logic             ep_inc, dur_load, dur_inc, set_load, set_inc, closing;

  // Stage 0: delay the driving value by the observed register's own latency.
  always_ff @(posedge clk) begin
    exp_q <= expected_i;
  end

  // An X/Z compare leaves match unknown; every decision below tests "if (match)"
  // so an unknown falls into the mismatch branch.
  assign match = (observed_i == exp_q);

  always_comb begin
    ep_inc   = 1'b0;
    dur_load = 1'b0;
    dur_inc  = 1'b0;
    set_load = 1'b0;
    set_inc  = 1'b0;
    closing  = 1'b0;
    case (state)
      S_TRACK: begin
        if (match) begin
          ep_inc = 1'b0;
        end else begin
          ep_inc   = 1'b1;
          dur_load = 1'b1;
        end
      end
      S_FORCED: begin
        if (match) begin
          set_load = 1'b1;
          closing  = (SETTLE <= 1);
        end else begin
          dur_inc = 1'b1;
        end
      end
      S_SETTLE: begin
        if (match) begin
          set_inc = 1'b1;
          closing = (set_cnt == SET_W'(SETTLE - 1));
        end else begin
          dur_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  force_mon_sat_cnt #(.W(CNT_W)) u_episode_cnt (
    .clk   (clk),
    .clr   (rst),
    .load1 (1'b0),
    .inc   (ep_inc),
    .cnt   (episode_cnt_o)
  );

  force_mon_sat_cnt #(.W(CNT_W)) u_duration_cnt (
    .clk   (clk),
    .clr   (rst),
    .load1 (dur_load),
    .inc   (dur_inc),
    .cnt   (dur_cnt)
  );

  force_mon_sat_cnt #(.W(SET_W)) u_settle_cnt (
    .clk   (clk),
    .clr   (rst),
    .load1 (set_load),
    .inc   (set_inc),
    .cnt   (set_cnt)
  );

  // Stage 1: episode FSM with registered status and pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_PRIME;
      forced_o        <= 1'b0;
      force_start_o   <= 1'b0;
      force_end_o     <= 1'b0;
      forced_value_o  <= '0;
      last_duration_o <= '0;
    end else begin
      force_start_o <= 1'b0;
      force_end_o   <= 1'b0;
      case (state)
        S_PRIME: state <= S_TRACK;
        S_TRACK: begin
          if (match) begin
            state <= S_TRACK;
          end else begin
            state          <= S_FORCED;
            forced_o       <= 1'b1;
            force_start_o  <= 1'b1;
            forced_value_o <= observed_i;
          end
        end
        S_FORCED, S_SETTLE: begin
          if (match) begin
            if (closing) begin
              state           <= S_TRACK;
              forced_o        <= 1'b0;
              force_end_o     <= 1'b1;
              last_duration_o <= dur_cnt;
            end else begin
              state <= S_SETTLE;
            end
          end else begin
            state <= S_FORCED;
          end
        end
        default: state <= S_PRIME;
      endcase
    end
  end

`ifdef FORCE_CHANGE_MONITOR_TRACE_EN
  always @(posedge clk) begin
    if (force_start_o)
      $display("[%0t] force_start value=%0h", $time, forced_value_o);
    if (force_end_o)
      $display("[%0t] force_end value=%0h duration=%0d", $time, forced_value_o, last_duration_o);
  end
`endif

endmodule
